// File: rtl/mbtrain_sb_pkg.sv
// Shared encodings for the MBTRAIN sideband exchange: message codes and
// the 3-bit state encoding used by the Vref-calibration initiator.
package mbtrain_sb_pkg;

  localparam logic [3:0] NONE       = 4'b0000;
  localparam logic [3:0] START_REQ  = 4'b0001;
  localparam logic [3:0] START_RESP = 4'b0010;
  localparam logic [3:0] END_REQ    = 4'b0011;
  localparam logic [3:0] END_RESP   = 4'b0100;

  localparam logic [2:0] ST_IDLE            = 3'd0;
  localparam logic [2:0] ST_SEND_START_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT_START_RESP = 3'd2;
  localparam logic [2:0] ST_PATTERN         = 3'd3;
  localparam logic [2:0] ST_SEND_END_REQ    = 3'd4;
  localparam logic [2:0] ST_WAIT_END_RESP   = 3'd5;
  localparam logic [2:0] ST_TEST_FINISHED   = 3'd6;
  localparam logic [2:0] ST_TIMEOUT_ERR     = 3'd7;

endpackage

// File: rtl/sb_valid_handshake.sv
// Sideband TX mux request: holds a pending message, raises valid when the
// RX-side block is not using the mux, and pulses msg_sent when valid drops.
module sb_valid_handshake (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic set_req,
  input  logic valid_rx,
  input  logic busy_negedge,
  output logic valid_tx,
  output logic msg_sent
);

  logic pending_r;
  logic valid_tx_r;
  logic valid_d_r;

  // Pending flag and valid request; a serializer-done pulse only counts while we own the mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= 1'b0;
      valid_tx_r <= 1'b0;
    end else if (clr) begin
      pending_r  <= 1'b0;
      valid_tx_r <= 1'b0;
    end else if (busy_negedge && valid_tx_r) begin
      pending_r  <= 1'b0;
      valid_tx_r <= 1'b0;
    end else begin
      if (set_req) begin
        pending_r <= 1'b1;
      end
      if (pending_r && !valid_rx && !valid_tx_r) begin
        valid_tx_r <= 1'b1;
      end
    end
  end

  // Delayed copy of valid for falling-edge detection; cleared on abort so no stale pulse follows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d_r <= 1'b0;
    end else if (clr) begin
      valid_d_r <= 1'b0;
    end else begin
      valid_d_r <= valid_tx_r;
    end
  end

  assign valid_tx = valid_tx_r;
  assign msg_sent = valid_d_r & ~valid_tx_r;

endmodule

// File: rtl/vref_cal_tx.sv
// MBTRAIN Vref-calibration TX initiator: start req/resp, pattern burst,
// end req/resp, then ack to the sequencer, with a handshake timeout.
module vref_cal_tx
  import mbtrain_sb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [3:0] i_decoded_sideband_message,
  input  logic       i_busy_negedge_detected,
  input  logic       i_valid_rx,
  input  logic       i_mainband_or_valtrain_test,
  input  logic       i_pattern_done,
  output logic [3:0] o_sideband_message,
  output logic       o_valid_tx,
  output logic       o_pattern_en,
  output logic       o_pattern_sel,
  output logic       o_test_ack,
  output logic       o_timeout
);

  logic [2:0]      state_r, next_s;
  logic [TO_W-1:0] cnt_r;
  logic            counting_s, timeout_hit_s, abort_s, msg_sent_s;
  logic            set_req_s, hs_clr_s;
  logic [3:0]      msg_r, msg_nxt_s;
  logic            pat_en_r, pat_en_nxt_s, pat_sel_r, pat_sel_nxt_s;
  logic            ack_r, ack_nxt_s, to_r, to_nxt_s;

  assign abort_s       = !i_en && (state_r != ST_IDLE);
  assign counting_s    = (state_r != ST_IDLE) && (state_r != ST_TEST_FINISHED) &&
                         (state_r != ST_TIMEOUT_ERR);
  assign timeout_hit_s = counting_s && (cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_s;
  end

  // Next-state decision; abort beats timeout, timeout beats any protocol advance
  always_comb begin
    next_s = state_r;
    if (abort_s) begin
      next_s = ST_IDLE;
    end else if (timeout_hit_s) begin
      next_s = ST_TIMEOUT_ERR;
    end else begin
      case (state_r)
        ST_IDLE:            next_s = i_en ? ST_SEND_START_REQ : ST_IDLE;
        ST_SEND_START_REQ:  next_s = msg_sent_s ? ST_WAIT_START_RESP : ST_SEND_START_REQ;
        ST_WAIT_START_RESP: next_s = (i_decoded_sideband_message == START_RESP) ? ST_PATTERN
                                                                                : ST_WAIT_START_RESP;
        ST_PATTERN:         next_s = i_pattern_done ? ST_SEND_END_REQ : ST_PATTERN;
        ST_SEND_END_REQ:    next_s = msg_sent_s ? ST_WAIT_END_RESP : ST_SEND_END_REQ;
        ST_WAIT_END_RESP:   next_s = (i_decoded_sideband_message == END_RESP) ? ST_TEST_FINISHED
                                                                              : ST_WAIT_END_RESP;
        ST_TEST_FINISHED:   next_s = ST_TEST_FINISHED;
        ST_TIMEOUT_ERR:     next_s = ST_TIMEOUT_ERR;
        default:            next_s = ST_IDLE;
      endcase
    end
  end

  // Output values to register, keyed on the transition being taken
  always_comb begin
    msg_nxt_s     = msg_r;
    pat_en_nxt_s  = pat_en_r;
    pat_sel_nxt_s = pat_sel_r;
    ack_nxt_s     = ack_r;
    to_nxt_s      = to_r;
    set_req_s     = 1'b0;
    hs_clr_s      = 1'b0;
    if (abort_s) begin
      msg_nxt_s     = NONE;
      pat_en_nxt_s  = 1'b0;
      pat_sel_nxt_s = 1'b0;
      ack_nxt_s     = 1'b0;
      to_nxt_s      = 1'b0;
      hs_clr_s      = 1'b1;
    end else if (timeout_hit_s) begin
      msg_nxt_s    = NONE;
      pat_en_nxt_s = 1'b0;
      to_nxt_s     = 1'b1;
      hs_clr_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_en) begin
            msg_nxt_s     = START_REQ;
            pat_sel_nxt_s = i_mainband_or_valtrain_test;
            set_req_s     = 1'b1;
          end else begin
            set_req_s = 1'b0;
          end
        end
        ST_WAIT_START_RESP: begin
          if (i_decoded_sideband_message == START_RESP) begin
            msg_nxt_s    = NONE;
            pat_en_nxt_s = 1'b1;
          end else begin
            pat_en_nxt_s = pat_en_r;
          end
        end
        ST_PATTERN: begin
          if (i_pattern_done) begin
            msg_nxt_s    = END_REQ;
            pat_en_nxt_s = 1'b0;
            set_req_s    = 1'b1;
          end else begin
            set_req_s = 1'b0;
          end
        end
        ST_WAIT_END_RESP: begin
          if (i_decoded_sideband_message == END_RESP) begin
            msg_nxt_s = NONE;
            ack_nxt_s = 1'b1;
          end else begin
            ack_nxt_s = ack_r;
          end
        end
        default: set_req_s = 1'b0;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_r     <= NONE;
      pat_en_r  <= 1'b0;
      pat_sel_r <= 1'b0;
      ack_r     <= 1'b0;
      to_r      <= 1'b0;
    end else begin
      msg_r     <= msg_nxt_s;
      pat_en_r  <= pat_en_nxt_s;
      pat_sel_r <= pat_sel_nxt_s;
      ack_r     <= ack_nxt_s;
      to_r      <= to_nxt_s;
    end
  end

  // Handshake timer: cleared in IDLE, frozen in terminal states, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (counting_s && (cnt_r != {TO_W{1'b1}})) begin
      cnt_r <= cnt_r + TO_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  sb_valid_handshake u_hs (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (hs_clr_s),
    .set_req      (set_req_s),
    .valid_rx     (i_valid_rx),
    .busy_negedge (i_busy_negedge_detected),
    .valid_tx     (o_valid_tx),
    .msg_sent     (msg_sent_s)
  );

  assign o_sideband_message = msg_r;
  assign o_pattern_en       = pat_en_r;
  assign o_pattern_sel      = pat_sel_r;
  assign o_test_ack         = ack_r;
  assign o_timeout          = to_r;

endmodule

// File: tb/tb_vref_cal_tx.sv
// Randomized scenario bench for vref_cal_tx: expectations come from the
// protocol timeline (message order, burst length, timeout deadline).
module tb_vref_cal_tx;
  import mbtrain_sb_pkg::*;

  localparam int TO_CYC = 150;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic [3:0] i_msg = 4'b0000;
  logic       i_busy = 1'b0;
  logic       i_valid_rx = 1'b0;
  logic       i_sel = 1'b0;
  logic       i_done = 1'b0;
  logic [3:0] o_sideband_message;
  logic       o_valid_tx, o_pattern_en, o_pattern_sel, o_test_ack, o_timeout;
  logic [8:0] outs;

  vref_cal_tx #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .i_en                        (i_en),
    .i_decoded_sideband_message  (i_msg),
    .i_busy_negedge_detected     (i_busy),
    .i_valid_rx                  (i_valid_rx),
    .i_mainband_or_valtrain_test (i_sel),
    .i_pattern_done              (i_done),
    .o_sideband_message          (o_sideband_message),
    .o_valid_tx                  (o_valid_tx),
    .o_pattern_en                (o_pattern_en),
    .o_pattern_sel               (o_pattern_sel),
    .o_test_ack                  (o_test_ack),
    .o_timeout                   (o_timeout)
  );

  assign outs = {o_sideband_message, o_valid_tx, o_pattern_en, o_pattern_sel, o_test_ack, o_timeout};

  always #5 clk = ~clk;

  int         vec_cnt = 0;
  int         miss_cnt = 0;
  int         cyc_cnt = 0;
  int         tx_rises = 0;
  int         pat_cycles = 0;
  logic [3:0] prev_msg = 4'b0000;
  logic       prev_valid = 1'b0;
  logic [3:0] msg_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  // One clock: inputs set before the call are sampled at the posedge inside it
  task automatic step();
    @(negedge clk);
    cyc_cnt++;
    if (o_sideband_message != prev_msg) msg_log.push_back(o_sideband_message);
    prev_msg = o_sideband_message;
    if (o_valid_tx && !prev_valid) tx_rises++;
    prev_valid = o_valid_tx;
    if (o_pattern_en) pat_cycles++;
  endtask

  // Serializer model: wait for valid (bounded), hold a while, then pulse busy-done
  task automatic serve(input string tag);
    int n = 0;
    while (!o_valid_tx && n < 16) begin
      step();
      n++;
    end
    chk({tag, "_valid_up"}, 32'(o_valid_tx), 32'd1);
    repeat ($urandom_range(0, 3)) begin
      step();
      chk({tag, "_valid_hold"}, 32'(o_valid_tx), 32'd1);
    end
    i_busy = 1'b1;
    step();
    i_busy = 1'b0;
    chk({tag, "_valid_drop"}, 32'(o_valid_tx), 32'd0);
  endtask

  task automatic run_nominal(input int resp_dly, input int pat_len, input logic sel);
    logic [3:0] exp_seq[4];
    exp_seq[0] = START_REQ; exp_seq[1] = NONE; exp_seq[2] = END_REQ; exp_seq[3] = NONE;
    msg_log.delete();
    tx_rises = 0;
    pat_cycles = 0;
    i_sel = sel;
    i_en = 1'b1;
    step();
    i_sel = ~sel;
    chk("nom_start_msg", 32'(o_sideband_message), 32'(START_REQ));
    chk("nom_sel_latch", 32'(o_pattern_sel), 32'(sel));
    chk("nom_valid_latency", 32'(o_valid_tx), 32'd0);
    serve("nom_start");
    repeat (resp_dly) step();
    i_msg = START_RESP;
    step();
    i_msg = NONE;
    chk("nom_pat_en_on", 32'(o_pattern_en), 32'd1);
    chk("nom_msg_clear", 32'(o_sideband_message), 32'(NONE));
    repeat (pat_len - 1) step();
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    chk("nom_pat_en_off", 32'(o_pattern_en), 32'd0);
    chk("nom_end_msg", 32'(o_sideband_message), 32'(END_REQ));
    serve("nom_end");
    repeat (resp_dly) step();
    i_msg = END_RESP;
    step();
    i_msg = NONE;
    chk("nom_ack", 32'(o_test_ack), 32'd1);
    repeat (3) step();
    chk("nom_ack_level", 32'(o_test_ack), 32'd1);
    chk("nom_sel_hold", 32'(o_pattern_sel), 32'(sel));
    chk("nom_seq_len", 32'(msg_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("nom_seq", (i < msg_log.size()) ? 32'(msg_log[i]) : 32'hF, 32'(exp_seq[i]));
    end
    chk("nom_tx_count", 32'(tx_rises), 32'd2);
    chk("nom_pat_cycles", 32'(pat_cycles), 32'(pat_len));
    i_en = 1'b0;
    step();
    chk("nom_release", 32'(outs), 32'd0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_outs", 32'(outs), 32'd0);

    for (int it = 0; it < 4; it++) begin
      run_nominal((it == 0) ? 5 : $urandom_range(1, 6),
                  (it == 0) ? 100 : $urandom_range(1, 100), 1'($urandom_range(0, 1)));
    end

    // Mux priority, spurious inputs, then timeout
    tx_rises = 0;
    i_valid_rx = 1'b1;
    i_en = 1'b1;
    t0 = cyc_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("prio_valid_low", 32'(o_valid_tx), 32'd0);
    end
    i_valid_rx = 1'b0;
    step();
    chk("prio_valid_rise", 32'(o_valid_tx), 32'd1);
    i_busy = 1'b1;
    step();
    i_busy = 1'b0;
    chk("prio_valid_drop", 32'(o_valid_tx), 32'd0);
    step();
    i_msg = END_RESP;
    i_done = 1'b1;
    step();
    i_msg = NONE;
    i_done = 1'b0;
    chk("spur_state", 32'(dut.state_r), 32'(ST_WAIT_START_RESP));
    chk("spur_pat_en", 32'(o_pattern_en), 32'd0);
    chk("spur_msg", 32'(o_sideband_message), 32'(START_REQ));
    while (cyc_cnt - t0 < TO_CYC) step();
    chk("to_not_early", 32'(o_timeout), 32'd0);
    step();
    chk("to_flag", 32'(o_timeout), 32'd1);
    chk("to_state", 32'(dut.state_r), 32'(ST_TIMEOUT_ERR));
    chk("to_valid", 32'(o_valid_tx), 32'd0);
    chk("to_msg", 32'(o_sideband_message), 32'(NONE));
    chk("prio_one_req", 32'(tx_rises), 32'd1);
    repeat (5) step();
    chk("to_level", 32'(o_timeout), 32'd1);
    i_en = 1'b0;
    step();
    chk("to_release", 32'(o_timeout), 32'd0);
    step();

    // Abort mid-pattern, restart, then async reset in WAIT_END_RESP
    i_en = 1'b1;
    step();
    serve("ab_start");
    repeat (2) step();
    i_msg = START_RESP;
    step();
    i_msg = NONE;
    repeat ($urandom_range(3, 20)) step();
    chk("ab_pat_en", 32'(o_pattern_en), 32'd1);
    i_en = 1'b0;
    step();
    chk("ab_clear", 32'(outs), 32'd0);
    chk("ab_state", 32'(dut.state_r), 32'(ST_IDLE));
    i_en = 1'b1;
    step();
    chk("ab_restart_msg", 32'(o_sideband_message), 32'(START_REQ));
    serve("rs_start");
    repeat (2) step();
    i_msg = START_RESP;
    step();
    i_msg = NONE;
    repeat (5) step();
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    serve("rs_end");
    step();
    chk("rs_state_wer", 32'(dut.state_r), 32'(ST_WAIT_END_RESP));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs), 32'd0);
    chk("async_rst_state", 32'(dut.state_r), 32'(ST_IDLE));
    i_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_outs", 32'(outs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
